// File: rtl/mul_arbiter.sv
// Round-robin front end for a shared, non-stallable pipelined multiplier.
// Registers the granted operand pair and tracks each product's owner with a tag pipeline.
module mul_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned LATENCY  = 4,
    parameter int unsigned A_BITS   = 32,
    parameter int unsigned B_BITS   = 32,
    localparam int unsigned ID_BITS  = (N_REQ > 2) ? $clog2(N_REQ) : 1,
    localparam int unsigned INF_BITS = $clog2(LATENCY + 3),
    localparam int unsigned Q_BITS   = A_BITS + B_BITS
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*A_BITS-1:0]   i_req_a,
    input  logic [N_REQ*B_BITS-1:0]   i_req_b,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic                      i_hold,
    output logic [A_BITS-1:0]         o_mul_a,
    output logic [B_BITS-1:0]         o_mul_b,
    input  logic [Q_BITS-1:0]         i_mul_q,
    output logic                      o_rsp_valid,
    output logic [ID_BITS-1:0]        o_rsp_id,
    output logic [Q_BITS-1:0]         o_rsp_q,
    output logic [INF_BITS-1:0]       o_inflight,
    output logic                      o_busy
);

    logic [ID_BITS-1:0]  ptr_q, ptr_d;
    logic [ID_BITS-1:0]  grant_idx;
    logic                grant_found;
    logic                xfer;
    logic [A_BITS-1:0]   mul_a_q, mul_a_d;
    logic [B_BITS-1:0]   mul_b_q, mul_b_d;
    logic [LATENCY:0]    tag_v_q;
    logic [ID_BITS-1:0]  tag_id_q [LATENCY+1];
    logic                rsp_valid_q;
    logic [ID_BITS-1:0]  rsp_id_q;
    logic [Q_BITS-1:0]   rsp_q_q;
    logic [INF_BITS-1:0] inflight_q, inflight_d;

    // Cyclic search from ptr; the candidate index wraps at N_REQ-1 so non-power-of-2 counts work.
    always_comb begin
        logic [ID_BITS-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!grant_found && i_req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == ID_BITS'(N_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        o_req_ready = '0;
        xfer        = grant_found & ~i_hold;
        if (xfer) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (xfer) begin
            ptr_d   = (grant_idx == ID_BITS'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            mul_a_d = i_req_a[grant_idx*A_BITS +: A_BITS];
            mul_b_d = i_req_b[grant_idx*B_BITS +: B_BITS];
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({xfer, rsp_valid_q})
            2'b10:   inflight_d = inflight_q + INF_BITS'(1);
            2'b01:   inflight_d = inflight_q - INF_BITS'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            inflight_q <= inflight_d;
        end
    end

    // Tag stage k lines up with multiplier stage k-1; the last stage coincides with i_mul_q.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_v_q <= '0;
            for (int unsigned i = 0; i <= LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_v_q     <= {tag_v_q[LATENCY-1:0], xfer};
            tag_id_q[0] <= grant_idx;
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
        end else begin
            rsp_valid_q <= tag_v_q[LATENCY];
            if (tag_v_q[LATENCY]) begin
                rsp_id_q <= tag_id_q[LATENCY];
                rsp_q_q  <= i_mul_q;
            end
        end
    end

    assign o_mul_a     = mul_a_q;
    assign o_mul_b     = mul_b_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_q     = rsp_q_q;
    assign o_inflight  = inflight_q;
    assign o_busy      = (inflight_q != '0);

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: models the external multiplier and predicts grants and responses
// from a queue of accepted requests stamped with their due cycle.
module tb_mul_arbiter;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int AB = 32;
    localparam int BB = 32;
    localparam int QB = AB + BB;
    localparam int RSP_LAT = L + 2;

    logic              clk;
    logic              i_rst_n;
    logic [N-1:0]      i_req_valid;
    logic [N*AB-1:0]   i_req_a;
    logic [N*BB-1:0]   i_req_b;
    logic [N-1:0]      o_req_ready;
    logic              i_hold;
    logic [AB-1:0]     o_mul_a;
    logic [BB-1:0]     o_mul_b;
    logic [QB-1:0]     i_mul_q;
    logic              o_rsp_valid;
    logic [1:0]        o_rsp_id;
    logic [QB-1:0]     o_rsp_q;
    logic [2:0]        o_inflight;
    logic              o_busy;

    mul_arbiter #(.N_REQ(N), .LATENCY(L), .A_BITS(AB), .B_BITS(BB)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .o_req_ready (o_req_ready),
        .i_hold      (i_hold),
        .o_mul_a     (o_mul_a),
        .o_mul_b     (o_mul_b),
        .i_mul_q     (i_mul_q),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_id    (o_rsp_id),
        .o_rsp_q     (o_rsp_q),
        .o_inflight  (o_inflight),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unreset multiplier model: garbage on its output until its pipeline has filled.
    logic [QB-1:0] mpipe [L];
    int            warm = 0;
    always @(posedge clk) begin
        mpipe[0] <= QB'(o_mul_a) * QB'(o_mul_b);
        for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
        if (warm < L) warm <= warm + 1;
    end
    assign i_mul_q = (warm < L) ? 64'hDEAD_BEEF_CAFE_F00D : mpipe[L-1];

    typedef struct {
        int            due;
        int            id;
        logic [QB-1:0] q;
    } rsp_t;

    rsp_t          rq[$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            ptr_m = 0;
    int            inflight_m = 0;
    int            last_grant = -1;
    logic [1:0]    last_id_m  = '0;
    logic [QB-1:0] last_q_m   = '0;
    logic [AB-1:0] mul_a_m    = '0;
    logic [BB-1:0] mul_b_m    = '0;
    logic [AB-1:0] op_a [N];
    logic [BB-1:0] op_b [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_clear();
        rq.delete();
        ptr_m      = 0;
        inflight_m = 0;
        last_id_m  = '0;
        last_q_m   = '0;
        mul_a_m    = '0;
        mul_b_m    = '0;
    endtask

    // One cycle: check registered outputs, drive requests, check the grant, advance the model.
    task automatic step(input logic [N-1:0] v, input logic hold);
        logic         exp_rv;
        logic [N-1:0] exp_rdy;
        int           g;
        @(negedge clk);
        exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
        chk("rsp_valid", 64'(o_rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            last_id_m = rq[0].id[1:0];
            last_q_m  = rq[0].q;
            void'(rq.pop_front());
        end
        chk("rsp_id", 64'(o_rsp_id), 64'(last_id_m));
        chk("rsp_q", o_rsp_q, last_q_m);
        chk("inflight", 64'(o_inflight), 64'(inflight_m));
        chk("busy", 64'(o_busy), 64'(inflight_m != 0));
        chk("mul_a", 64'(o_mul_a), 64'(mul_a_m));
        chk("mul_b", 64'(o_mul_b), 64'(mul_b_m));

        i_req_valid = v;
        i_hold      = hold;
        for (int k = 0; k < N; k++) begin
            i_req_a[k*AB +: AB] = op_a[k];
            i_req_b[k*BB +: BB] = op_b[k];
        end
        #1;
        g = -1;
        if (!hold) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (ptr_m + i) % N;
                if (g < 0 && v[c]) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", 64'(o_req_ready), 64'(exp_rdy));

        last_grant = g;
        if (g >= 0) begin
            rq.push_back('{due: cyc + RSP_LAT, id: g, q: QB'(op_a[g]) * QB'(op_b[g])});
            ptr_m   = (g + 1) % N;
            mul_a_m = op_a[g];
            mul_b_m = op_b[g];
        end
        inflight_m = inflight_m + ((g >= 0) ? 1 : 0) - (exp_rv ? 1 : 0);
        cyc++;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_hold      = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("rst_rsp_q", o_rsp_q, 64'd0);
        chk("rst_inflight", 64'(o_inflight), 64'd0);
        chk("rst_mul_a", 64'(o_mul_a), 64'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        model_clear();
        cyc += 2;
    endtask

    initial begin
        logic [31:0] r;
        i_rst_n     = 1'b1;
        i_req_valid = '0;
        i_hold      = 1'b0;
        i_req_a     = '0;
        i_req_b     = '0;
        for (int k = 0; k < N; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end
        pulse_reset();

        // Idle after reset while the multiplier model still drives garbage.
        repeat (20) step('0, 1'b0);

        // Requester 2 alone: 3*5.
        op_a[2] = 32'd3; op_b[2] = 32'd5;
        step(4'b0100, 1'b0);
        repeat (8) step('0, 1'b0);

        // All four valid continuously, a=k+1, b=10.
        for (int k = 0; k < N; k++) begin
            op_a[k] = 32'(k + 1);
            op_b[k] = 32'd10;
        end
        repeat (8) step(4'b1111, 1'b0);
        repeat (8) step('0, 1'b0);

        // Requesters 0 and 2 with a two-cycle hold in the middle.
        for (int c = 0; c < 8; c++) step(4'b0101, (c == 2) || (c == 3));
        repeat (8) step('0, 1'b0);

        // Full-width product.
        op_a[1] = 32'hFFFF_FFFF; op_b[1] = 32'hFFFF_FFFF;
        step(4'b0010, 1'b0);
        repeat (8) step('0, 1'b0);

        // Three acceptances, then reset mid-flight: those responses must never appear.
        repeat (3) step(4'b1111, 1'b0);
        step('0, 1'b0);
        pulse_reset();
        step(4'b1111, 1'b0);
        repeat (9) step('0, 1'b0);

        // Randomized traffic with occasional holds and resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end else begin
                r = $urandom;
                step(r[N-1:0], $urandom_range(0, 4) == 0);
                if (last_grant >= 0) begin
                    op_a[last_grant] = rnd_op();
                    op_b[last_grant] = rnd_op();
                end
            end
        end
        repeat (10) step('0, 1'b0);
        chk("drained", 64'(rq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter that shares one fixed-latency, non-stallable pipelined multiplier (`mul`) between `N_REQ` requesters. Each cycle it accepts at most one operand pair, registers it onto the multiplier inputs, and carries a tag pipeline matched to the multiplier latency. Each product returns to its requester with its ID. It sits between the datapath clients and the shared `mul` instance; the multiplier itself is instantiated outside this block.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `LATENCY`, 4: latency parameter of the attached `mul`, ≥1.
- `A_BITS`, 32: operand A width.
- `B_BITS`, 32: operand B width.
- Localparam `ID_BITS` = max(1, clog2(N_REQ)).

Ports:
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_req_valid`  in  N_REQ  per-requester request valid.
- `i_req_a`  in  N_REQ*A_BITS  operand A; requester k occupies bits [k*A_BITS +: A_BITS].
- `i_req_b`  in  N_REQ*B_BITS  operand B, same packing.
- `o_req_ready`  out  N_REQ  one-hot grant. Transfer occurs when valid&ready in the same cycle.
- `i_hold`  in  1  suppresses all grants this cycle.
- `o_mul_a`  out  A_BITS  registered operand to `mul.i_a`.
- `o_mul_b`  out  B_BITS  registered operand to `mul.i_b`.
- `i_mul_q`  in  A_BITS+B_BITS  product from `mul.o_q`.
- `o_rsp_valid`  out  1  registered result strobe, one cycle per accepted request.
- `o_rsp_id`  out  ID_BITS  requester index of the result.
- `o_rsp_q`  out  A_BITS+B_BITS  product.
- `o_inflight`  out  clog2(LATENCY+3)  count of accepted requests whose response has not yet been emitted.
- `o_busy`  out  1  o_inflight != 0.

## Operation
- **Arbitration pointer `ptr`** (ID_BITS, reset 0).
  - Grant goes to the first k with i_req_valid[k]=1, searching cyclically from ptr.
  - `o_req_ready` is combinational: one-hot at the grant index, all-zero if i_hold=1 or no valid.
- **On transfer of requester g:**
  - `ptr` ← (g+1) mod N_REQ. When N_REQ is not a power of 2, the pointer wraps from N_REQ-1 to 0.
  - `o_mul_a`/`o_mul_b` ← requester g's operands.
  - Tag stage 0 ← {1, g}.
- **No transfer:**
  - `ptr` holds.
  - `o_mul_a`/`o_mul_b` hold their previous values (the multiplier keeps computing; the result is ignored).
  - Tag stage 0 ← {0, x}.
- **Tag pipeline:** LATENCY+1 stages of {valid, id}, shifted every cycle with no stall. The multiplier has no stall either, so the tag pipeline never stops.
- **Output register:** every edge, `o_rsp_valid` ← last tag valid. When that valid is 1, `o_rsp_id` ← its id and `o_rsp_q` ← i_mul_q; otherwise `o_rsp_id`/`o_rsp_q` hold.
- **Backpressure:** there is none on responses; requesters must sink `o_rsp_*` unconditionally. Throughput is 1 request per cycle.
- **Response ordering:** responses return in acceptance order.
- **o_inflight:**
  - +1 on a transfer.
  - −1 on `o_rsp_valid`.
  - Unchanged when both happen in the same cycle.
  - Never exceeds LATENCY+2.
- **Arithmetic:** unsigned, full width. The product is not truncated; the block passes i_mul_q unchanged.
- **Reset (asynchronous, any time, including mid-operation):**
  - ptr=0; o_mul_a=0; o_mul_b=0.
  - All tag valids = 0.
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_q=0.
  - o_inflight=0, o_busy=0.
  - In-flight requests are discarded and produce no response. The multiplier's stale pipeline contents (`mul` has no reset) must never produce `o_rsp_valid`.

## Timing
- **Request latency:** transfer in cycle t → o_mul_a/b valid in cycle t+1 → `mul` stage 0 captures at the end of t+1 → i_mul_q valid in cycle t+LATENCY+1 → `o_rsp_valid`=1 in cycle t+LATENCY+2. The default latency is 6 cycles.
- **Grant combinational path:** `o_req_ready` depends combinationally on i_req_valid, i_hold and ptr. Requesters must not make `i_req_valid` depend on `o_req_ready`.
- **Request held under a grant:** a request held valid while unserved keeps its operands stable. An accepted request may change its operands the next cycle.
- **Fairness:** a continuously valid requester is granted within N_REQ transfer cycles.
- **i_hold:** affects acceptance only. Responses already in flight still emerge on schedule.

## Test plan
- Reset release with stale X/garbage on i_mul_q, no requests for 20 cycles → o_rsp_valid stays 0, o_inflight=0, all outputs 0.
- Requester 2 alone sends a=3, b=5 in cycle 10 → o_req_ready=4'b0100 in cycle 10; o_rsp_valid, o_rsp_id=2, o_rsp_q=15 in cycle 16 only.
- All 4 valid continuously from cycle 10 with a=k+1, b=10 → grants 0,1,2,3,0,… on consecutive cycles; responses start at cycle 16 with ids 0,1,2,3 and q=10,20,30,40, one per cycle.
- Requesters 0 and 2 continuously valid, i_hold=1 in cycles 12–13 → grants alternate 0,2,0,…; no ready in 12–13; the pointer resumes without skipping; response gaps appear 6 cycles later.
- a=0xFFFFFFFF, b=0xFFFFFFFF from requester 1 → o_rsp_q=0xFFFFFFFE00000001, id=1.
- Three requests accepted, i_rst_n pulsed low for 1 cycle two cycles later → no responses ever appear for them; the first request after reset is granted from index 0 with normal 6-cycle latency.
